// File: rtl/touch_coord_filter_if.sv
// Pen, sample and report signals of touch_coord_filter.
// master drives the ADC side and consumes reports; slave is the filter.
interface touch_coord_filter_if;
  logic        iTOUCH_IRQ;
  logic [11:0] iX_COORD;
  logic [11:0] iY_COORD;
  logic        iNEW_COORD;
  logic        iTOUCH_ACK;
  logic [9:0]  oTOUCH_X;
  logic [9:0]  oTOUCH_Y;
  logic        oTOUCH_VALID;
  logic        oPEN_DOWN;
  logic        oDROP;

  modport master (
    output iTOUCH_IRQ,
    output iX_COORD,
    output iY_COORD,
    output iNEW_COORD,
    output iTOUCH_ACK,
    input  oTOUCH_X,
    input  oTOUCH_Y,
    input  oTOUCH_VALID,
    input  oPEN_DOWN,
    input  oDROP
  );

  modport slave (
    input  iTOUCH_IRQ,
    input  iX_COORD,
    input  iY_COORD,
    input  iNEW_COORD,
    input  iTOUCH_ACK,
    output oTOUCH_X,
    output oTOUCH_Y,
    output oTOUCH_VALID,
    output oPEN_DOWN,
    output oDROP
  );
endinterface

// File: rtl/touch_coord_filter.sv
// Debounce pen-down, average ADC samples, map to LCD pixels.
// Optional outlier rejection: define TOUCH_OUTLIER_REJECT_EN.
module touch_coord_filter #(
  parameter int NSAMP_LOG2  = 2,
  parameter int DEB_CYC     = 50000,
  parameter int OUTLIER_THR = 64
) (
  input logic iCLK,
  input logic iRST,
  touch_coord_filter_if.slave bus
);

  localparam int AW = 12 + NSAMP_LOG2;
  localparam int CW = NSAMP_LOG2 + 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [CW-1:0] SAMP_LAST = CW'((1 << NSAMP_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    COLLECT,
    HOLD
  } state_t;

  state_t        state;
  logic [DW-1:0] deb_cnt;
  logic [7:0]    hold_cnt;
  logic [CW-1:0] samp_cnt;
  logic [AW-1:0] acc_x;
  logic [AW-1:0] acc_y;
  logic          pen_q;

  logic          s1_v;
  logic [11:0]   s1_x;
  logic [11:0]   s1_y;
  logic          s2_v;
  logic [8:0]    s2_qx;
  logic [8:0]    s2_qy;

  logic [9:0]    x_q;
  logic [9:0]    y_q;
  logic          valid_q;
  logic          drop_q;

  logic          take;
  logic          keep;
  logic [AW-1:0] sum_x;
  logic [AW-1:0] sum_y;
  logic signed [10:0] mx;
  logic signed [10:0] my;

  // A strobe in the same cycle as pen release is never taken.
  assign take  = (state == COLLECT) && bus.iTOUCH_IRQ && bus.iNEW_COORD;
  assign sum_x = acc_x + AW'(bus.iX_COORD);
  assign sum_y = acc_y + AW'(bus.iY_COORD);

`ifdef TOUCH_OUTLIER_REJECT_EN
  localparam logic [12:0] THR = 13'(OUTLIER_THR);

  logic [11:0] x_first;
  logic [11:0] y_first;
  logic [11:0] dx;
  logic [11:0] dy;

  assign dx = (bus.iX_COORD >= x_first) ?
              bus.iX_COORD - x_first :
              x_first - bus.iX_COORD;
  assign dy = (bus.iY_COORD >= y_first) ?
              bus.iY_COORD - y_first :
              y_first - bus.iY_COORD;
  assign keep = (samp_cnt == '0) ||
                (({1'b0, dx} <= THR) && ({1'b0, dy} <= THR));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_first <= '0;
      y_first <= '0;
    end else if (take && samp_cnt == '0) begin
      x_first <= bus.iX_COORD;
      y_first <= bus.iY_COORD;
    end
  end
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      samp_cnt <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      pen_q    <= 1'b0;
      s1_v     <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_v <= 1'b0;
      unique case (state)
        IDLE: begin
          deb_cnt <= '0;
          if (bus.iTOUCH_IRQ) begin
            if (DEB_CYC <= 1) begin
              state <= COLLECT;
              pen_q <= 1'b1;
            end else begin
              state   <= DEBOUNCE;
              deb_cnt <= DW'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!bus.iTOUCH_IRQ) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= COLLECT;
            pen_q   <= 1'b1;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        COLLECT: begin
          if (!bus.iTOUCH_IRQ) begin
            state    <= HOLD;
            hold_cnt <= '0;
            samp_cnt <= '0;
            acc_x    <= '0;
            acc_y    <= '0;
          end else if (take && keep) begin
            if (samp_cnt == SAMP_LAST) begin
              samp_cnt <= '0;
              acc_x    <= '0;
              acc_y    <= '0;
              s1_v     <= 1'b1;
              s1_x     <= 12'(sum_x >> NSAMP_LOG2);
              s1_y     <= 12'(sum_y >> NSAMP_LOG2);
            end else begin
              samp_cnt <= samp_cnt + CW'(1);
              acc_x    <= sum_x;
              acc_y    <= sum_y;
            end
          end
        end
        HOLD: begin
          if (bus.iTOUCH_IRQ) begin
            state <= COLLECT;
          end else if (hold_cnt == 8'hFF) begin
            state <= IDLE;
            pen_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Screen is rotated: panel Y drives pixel column, panel X the row.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s2_v  <= 1'b0;
      s2_qx <= '0;
      s2_qy <= '0;
    end else begin
      s2_v  <= s1_v;
      s2_qx <= 9'(s1_y / 12'd10);
      s2_qy <= 9'(s1_x / 12'd17);
    end
  end

  assign mx = 11'sd400 - $signed({2'b00, s2_qx});
  assign my = 11'sd240 - $signed({2'b00, s2_qy});

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else if (s2_v) begin
      x_q     <= mx[10] ? 10'd0 : mx[9:0];
      y_q     <= my[10] ? 10'd0 : my[9:0];
      valid_q <= 1'b1;
      drop_q  <= valid_q && !bus.iTOUCH_ACK;
    end else begin
      drop_q <= 1'b0;
      if (bus.iTOUCH_ACK) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.oTOUCH_X     = x_q;
  assign bus.oTOUCH_Y     = y_q;
  assign bus.oTOUCH_VALID = valid_q;
  assign bus.oPEN_DOWN    = pen_q;
  assign bus.oDROP        = drop_q;

endmodule

// File: tb/tb_touch_coord_filter.sv
// Directed plus randomized bench for touch_coord_filter.
// Expected reports come from a sample-queue model of the averaging rules.
module tb_touch_coord_filter;
  localparam int NL2 = 2;
  localparam int NS  = 4;
  localparam int DEB = 20;
  localparam int THR = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  touch_coord_filter_if bus();

  touch_coord_filter #(
    .NSAMP_LOG2 (NL2),
    .DEB_CYC    (DEB),
    .OUTLIER_THR(THR)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int qx[$];
  int qy[$];
  int ex = 0;
  int ey = 0;
  bit vexp = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_clear();
    qx.delete();
    qy.delete();
  endfunction

  function automatic bit model_push(input int x, input int y);
    int sx;
    int sy;
    sx = 0;
    sy = 0;
`ifdef TOUCH_OUTLIER_REJECT_EN
    if (qx.size() > 0) begin
      if (x - qx[0] > THR || qx[0] - x > THR ||
          y - qy[0] > THR || qy[0] - y > THR)
        return 1'b0;
    end
`endif
    qx.push_back(x);
    qy.push_back(y);
    if (qx.size() < NS)
      return 1'b0;
    foreach (qx[i]) begin
      sx += qx[i];
      sy += qy[i];
    end
    ex = 400 - (sy / NS) / 10;
    ey = 240 - (sx / NS) / 17;
    if (ex < 0) ex = 0;
    if (ey < 0) ey = 0;
    model_clear();
    return 1'b1;
  endfunction

  task automatic strobe(input int x, input int y, output bit done);
    step($urandom_range(0, 3));
    bus.iX_COORD   = 12'(x);
    bus.iY_COORD   = 12'(y);
    bus.iNEW_COORD = 1'b1;
    step();
    bus.iNEW_COORD = 1'b0;
    done = model_push(x, y);
  endtask

  task automatic rand_window(output bit done);
    int bx;
    int by;
    bx = int'($urandom_range(0, 4031));
    by = int'($urandom_range(0, 4031));
    done = 1'b0;
    for (int i = 0; i < NS; i++)
      strobe(bx + int'($urandom_range(0, 64)),
             by + int'($urandom_range(0, 64)), done);
  endtask

  task automatic expect_report(input string tag,
                               input bit drop_exp,
                               input bit ack_arr);
    step();
    check({tag, "_lat1_valid"}, bus.oTOUCH_VALID, vexp);
    if (ack_arr) bus.iTOUCH_ACK = 1'b1;
    step();
    bus.iTOUCH_ACK = 1'b0;
    check({tag, "_valid"}, bus.oTOUCH_VALID, 1);
    check({tag, "_x"}, bus.oTOUCH_X, ex);
    check({tag, "_y"}, bus.oTOUCH_Y, ey);
    check({tag, "_drop"}, bus.oDROP, drop_exp);
    vexp = 1'b1;
    step();
    check({tag, "_drop_end"}, bus.oDROP, 0);
    check({tag, "_hold"}, bus.oTOUCH_VALID, 1);
  endtask

  task automatic do_ack(input string tag);
    bus.iTOUCH_ACK = 1'b1;
    step();
    bus.iTOUCH_ACK = 1'b0;
    vexp = 1'b0;
    check({tag, "_ackclr"}, bus.oTOUCH_VALID, 0);
  endtask

  task automatic pen_time(output int n);
    n = 0;
    bus.iTOUCH_IRQ = 1'b1;
    while (bus.oPEN_DOWN !== 1'b1 && n < 500) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int n;
    bus.iTOUCH_IRQ = 1'b0;
    bus.iNEW_COORD = 1'b0;
    bus.iX_COORD   = '0;
    bus.iY_COORD   = '0;
    bus.iTOUCH_ACK = 1'b0;
    rst = 1'b1;
    step(3);
    check("rst_x", bus.oTOUCH_X, 0);
    check("rst_y", bus.oTOUCH_Y, 0);
    check("rst_valid", bus.oTOUCH_VALID, 0);
    check("rst_pen", bus.oPEN_DOWN, 0);
    check("rst_drop", bus.oDROP, 0);
    rst = 1'b0;
    step();

    // Interrupted debounce with a strobe that must be ignored.
    bus.iTOUCH_IRQ = 1'b1;
    step(DEB / 2);
    bus.iX_COORD   = 12'd4000;
    bus.iY_COORD   = 12'd10;
    bus.iNEW_COORD = 1'b1;
    step();
    bus.iNEW_COORD = 1'b0;
    check("deb_mid_pen", bus.oPEN_DOWN, 0);
    bus.iTOUCH_IRQ = 1'b0;
    step();
    check("deb_abort_pen", bus.oPEN_DOWN, 0);
    pen_time(n);
    check("deb_len", n, DEB);

    for (int i = 0; i < NS; i++) strobe(1700, 2000, done);
    expect_report("basic", 1'b0, 1'b0);
    check("basic_x_const", bus.oTOUCH_X, 200);
    check("basic_y_const", bus.oTOUCH_Y, 140);
    step(6);
    check("basic_held", bus.oTOUCH_VALID, 1);
    do_ack("basic");
    bus.iTOUCH_ACK = 1'b1;
    step();
    bus.iTOUCH_ACK = 1'b0;
    check("stray_ack_valid", bus.oTOUCH_VALID, 0);
    check("stray_ack_drop", bus.oDROP, 0);

    for (int i = 0; i < NS; i++) strobe(100, 4095, done);
    expect_report("clamp", 1'b0, 1'b0);
    check("clamp_x_const", bus.oTOUCH_X, 0);
    check("clamp_y_const", bus.oTOUCH_Y, 235);
    do_ack("clamp");

    for (int r = 0; r < 6; r++) begin
      rand_window(done);
      expect_report($sformatf("rand%0d", r), 1'b0, 1'b0);
      do_ack($sformatf("rand%0d", r));
    end

    rand_window(done);
    expect_report("ovA", 1'b0, 1'b0);
    rand_window(done);
    expect_report("ovB", 1'b1, 1'b0);
    rand_window(done);
    expect_report("ovC", 1'b0, 1'b1);
    do_ack("ovC");

    for (int i = 0; i < 3; i++) strobe(1000, 2000, done);
    strobe(1500, 2000, done);
    if (!done) begin
      step(2);
      check("outl_noreport", bus.oTOUCH_VALID, 0);
      strobe(1000, 2000, done);
    end
    expect_report("outl", 1'b0, 1'b0);
`ifdef TOUCH_OUTLIER_REJECT_EN
    check("outl_y_const", bus.oTOUCH_Y, 182);
`else
    check("outl_y_const", bus.oTOUCH_Y, 174);
`endif
    do_ack("outl");

    // Partial window, then release with a coincident strobe.
    strobe(300, 300, done);
    strobe(300, 300, done);
    bus.iTOUCH_IRQ = 1'b0;
    bus.iX_COORD   = 12'd0;
    bus.iY_COORD   = 12'd0;
    bus.iNEW_COORD = 1'b1;
    step();
    bus.iNEW_COORD = 1'b0;
    model_clear();
    check("rel_pen_hold", bus.oPEN_DOWN, 1);
    step(200);
    check("rel_pen_200", bus.oPEN_DOWN, 1);
    step(99);
    check("rel_pen_idle", bus.oPEN_DOWN, 0);
    check("rel_valid", bus.oTOUCH_VALID, 0);
    pen_time(n);
    check("rel_redeb_len", n, DEB);
    rand_window(done);
    expect_report("fresh", 1'b0, 1'b0);
    do_ack("fresh");

    bus.iTOUCH_IRQ = 1'b0;
    step(100);
    check("hold_pen", bus.oPEN_DOWN, 1);
    bus.iTOUCH_IRQ = 1'b1;
    step();
    check("hold_back_pen", bus.oPEN_DOWN, 1);
    rand_window(done);
    expect_report("hold_back", 1'b0, 1'b0);
    do_ack("hold_back");

    rand_window(done);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    vexp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("mrst_valid%0d", i), bus.oTOUCH_VALID, 0);
    end
    check("mrst_x", bus.oTOUCH_X, 0);
    check("mrst_y", bus.oTOUCH_Y, 0);
    check("mrst_pen", bus.oPEN_DOWN, 0);
    check("mrst_drop", bus.oDROP, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/touch_coord_filter.md
TOUCH_COORD_FILTER -- requirements
Module: touch_coord_filter

Interface
REQ-001 Parameter NSAMP_LOG2, default 2, log2 of the number of samples averaged per report (window = 4).
REQ-002 Parameter DEB_CYC, default 50000, number of consecutive pen-down cycles required before sampling (1 ms at 50 MHz).
REQ-003 Parameter OUTLIER_THR, default 64, maximum per-axis deviation in ADC counts from the first sample of the window (used only with TOUCH_OUTLIER_REJECT_EN).
REQ-004 iCLK  in  1  system clock, 50 MHz; one clock domain only.
REQ-005 iRST  in  1  synchronous, active-high reset.
REQ-006 iTOUCH_IRQ  in  1  pen-down level from the ADC SPI controller, 1 = pen down.
REQ-007 iX_COORD  in  12  raw ADC X sample.
REQ-008 iY_COORD  in  12  raw ADC Y sample.
REQ-009 iNEW_COORD  in  1  one-cycle strobe; iX_COORD and iY_COORD are valid in the same cycle.
REQ-010 iTOUCH_ACK  in  1  consumer acknowledge of the current report.
REQ-011 oTOUCH_X  out  10  LCD pixel column, 0..400.
REQ-012 oTOUCH_Y  out  10  LCD pixel row, 0..240.
REQ-013 oTOUCH_VALID  out  1  report pending; held high until acknowledged.
REQ-014 oPEN_DOWN  out  1  debounced pen state.
REQ-015 oDROP  out  1  one-cycle pulse when an unacknowledged report is overwritten.

Function
REQ-016 The state machine SHALL have four states: IDLE, DEBOUNCE, COLLECT and HOLD.
REQ-017 IDLE -> DEBOUNCE when iTOUCH_IRQ=1; DEBOUNCE -> COLLECT after DEB_CYC consecutive cycles with iTOUCH_IRQ=1; DEBOUNCE -> IDLE on iTOUCH_IRQ=0, with the counter cleared.
REQ-018 oPEN_DOWN SHALL be 1 exactly in the COLLECT and HOLD states.
REQ-019 In COLLECT, each accepted iNEW_COORD SHALL add X and Y to 14-bit accumulators and increment a sample counter.
REQ-020 Strobes received in IDLE and DEBOUNCE SHALL be ignored.
REQ-021 When the counter reaches 2^NSAMP_LOG2: avg = accumulator >> NSAMP_LOG2 (truncate); then clear the accumulators and counter and stay in COLLECT.
REQ-022 Mapping SHALL use floor division, computed signed at 11 bits: oTOUCH_X = max(0, 400 - avgY/10) and oTOUCH_Y = max(0, 240 - avgX/17).
REQ-023 oTOUCH_X, oTOUCH_Y and oTOUCH_VALID SHALL update on the second rising edge after the edge that accepts the last strobe of the window (latency 2).
REQ-024 oTOUCH_VALID SHALL remain 1 until a cycle with iTOUCH_ACK=1, and SHALL clear on the next edge.
REQ-025 iTOUCH_ACK while oTOUCH_VALID=0 SHALL be ignored.
REQ-026 A new report arriving while oTOUCH_VALID=1 with no ACK in that cycle SHALL overwrite the coordinates, keep VALID=1 and pulse oDROP.
REQ-027 A new report arriving in the same cycle as an ACK SHALL load the new coordinates, keep VALID=1 and not pulse oDROP.
REQ-028 COLLECT -> HOLD on iTOUCH_IRQ=0: discard the partial window with no report; a report already pending stays valid.
REQ-029 HOLD SHALL wait 256 cycles; if iTOUCH_IRQ returns to 1 within the wait -> COLLECT with no new debounce, otherwise -> IDLE.
REQ-030 An iNEW_COORD coinciding with iTOUCH_IRQ falling SHALL be discarded.

Reset
REQ-031 While iRST=1 at a clock edge: state = IDLE; all counters and accumulators = 0; oTOUCH_X = 0, oTOUCH_Y = 0, oTOUCH_VALID = 0, oPEN_DOWN = 0, oDROP = 0.
REQ-032 Reset asserted mid-window or mid-pipeline SHALL discard all partial data; no report SHALL emerge after reset releases.

Configuration
REQ-033 With macro TOUCH_OUTLIER_REJECT_EN defined: a sample other than the first of a window whose |X - X_first| or |Y - Y_first| exceeds OUTLIER_THR SHALL be dropped (not accumulated, not counted).
REQ-034 Without TOUCH_OUTLIER_REJECT_EN: every accepted sample SHALL be accumulated, and OUTLIER_THR has no effect.

Verification
REQ-035 Pen down for DEB_CYC cycles, then 4 strobes X=1700/Y=2000 -> one report X=200, Y=140, VALID high 2 cycles after the 4th strobe, held until ACK.
REQ-036 Pen down, 4 strobes X=100/Y=4095 -> X=0 (clamped), Y=235.
REQ-037 Pen down, 2 strobes, then iTOUCH_IRQ=0 for 300 cycles -> no report, oPEN_DOWN falls, state IDLE.
REQ-038 Two full windows with no ACK -> oDROP pulses once, outputs show the second window; ACK coinciding with a third window -> no oDROP.
REQ-039 Strobes X=1000,1000,1000,1500, Y=2000 -> without macro Y=174; with macro the 4th sample is dropped, then a 5th X=1000 gives Y=182.
REQ-040 Assert iRST one cycle after the 4th strobe -> oTOUCH_VALID never rises and all outputs read 0.
